popcount_window_accumulator: RTL and testbench



---
 rtl/popcount_window_accumulator.sv | 89 ++++++++
 tb/tb_popcount_window_accumulator.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/popcount_window_accumulator.sv
// popcount_window_accumulator: sliding-window sum of popcount results with threshold flag (optional avg_o via POPCOUNT_WIN_AVG_EN)
module popcount_window_accumulator #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 2,
   parameter int WINDOW = 8,
   localparam int SUM_W = CNT_W + $clog2(WINDOW)
) (
   input  logic             clk_i,
   input  logic             arst_i,
   input  logic [CNT_W-1:0] data_i,
   input  logic             data_val_i,
   input  logic             clear_i,
   input  logic [SUM_W-1:0] thresh_i,
   output logic [SUM_W-1:0] sum_o,
   output logic             sum_val_o,
   output logic             above_o,
`ifdef POPCOUNT_WIN_AVG_EN
   output logic [CNT_W-1:0] avg_o,
`endif
   output logic             fill_o
);
   localparam int PTR_W = $clog2(WINDOW);
   localparam int FILL_W = $clog2(WINDOW + 1);
`ifdef POPCOUNT_WIN_AVG_EN
   if ((WINDOW & (WINDOW - 1)) != 0) begin : g_win_pow2
      $error("WINDOW must be a power of two when averaging is enabled");
   end
`endif
   logic [CNT_W-1:0]  mem [WINDOW];
   logic [PTR_W-1:0]  wr_ptr;
   logic [FILL_W-1:0] fill_cnt, fill_next;
   logic [SUM_W-1:0]  acc, acc_next;
   logic [CNT_W-1:0]  old;
   logic              full, full_next, acpt;
   // Retire the oldest sample only once the window is full; before that the slot is stale
   always_comb begin
      acpt      = data_val_i && !clear_i;
      full      = fill_cnt == FILL_W'(WINDOW);
      old       = full ? mem[wr_ptr] : '0;
      acc_next  = acc + SUM_W'(data_i) - SUM_W'(old);
      fill_next = full ? fill_cnt : fill_cnt + FILL_W'(1);
      full_next = fill_next == FILL_W'(WINDOW);
   end
   // Sample buffer is left unreset; fill gating hides its power-up contents
   always_ff @(posedge clk_i) begin
      if (acpt) mem[wr_ptr] <= data_i;
   end
   // Window state and output registers; clear flushes everything, outputs move only on a full window
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         wr_ptr    <= '0;
         fill_cnt  <= '0;
         acc       <= '0;
         sum_o     <= '0;
         sum_val_o <= 1'b0;
         above_o   <= 1'b0;
         fill_o    <= 1'b0;
`ifdef POPCOUNT_WIN_AVG_EN
         avg_o     <= '0;
`endif
      end else if (clear_i) begin
         wr_ptr    <= '0;
         fill_cnt  <= '0;
         acc       <= '0;
         sum_o     <= '0;
         sum_val_o <= 1'b0;
         above_o   <= 1'b0;
         fill_o    <= 1'b0;
`ifdef POPCOUNT_WIN_AVG_EN
         avg_o     <= '0;
`endif
      end else begin
         sum_val_o <= acpt && full_next;
         if (acpt) begin
            wr_ptr   <= wr_ptr == PTR_W'(WINDOW - 1) ? '0 : wr_ptr + PTR_W'(1);
            fill_cnt <= fill_next;
            acc      <= acc_next;
            fill_o   <= full_next;
            if (full_next) begin
               sum_o   <= acc_next;
               above_o <= acc_next > thresh_i;
`ifdef POPCOUNT_WIN_AVG_EN
               avg_o   <= CNT_W'(acc_next >> PTR_W);
`endif
            end
         end
      end
   end
endmodule

// File: tb/tb_popcount_window_accumulator.sv
// tb_popcount_window_accumulator: directed table-driven check of the windowed popcount accumulator (WINDOW=4)
module tb_popcount_window_accumulator;
   localparam int WIDTH = 32;
   localparam int WINDOW = 4;
   localparam int CNT_W = $clog2(WIDTH) + 2;
   localparam int SUM_W = CNT_W + $clog2(WINDOW);

   typedef struct {
      bit       val;
      bit       clr;
      int       data;
      int       thr;
      int       sum;
      bit       sv;
      bit       above;
      bit       fill;
      int       avg;
   } vec_t;

   logic             clk = 1'b0;
   logic             arst = 1'b1;
   logic [CNT_W-1:0] data = '0;
   logic             data_val = 1'b0;
   logic             clear = 1'b0;
   logic [SUM_W-1:0] thresh = '0;
   logic [SUM_W-1:0] sum;
   logic             sum_val, above, fill;
`ifdef POPCOUNT_WIN_AVG_EN
   logic [CNT_W-1:0] avg;
`endif
   int checks = 0;
   int failures = 0;
   vec_t vecs[$];

   popcount_window_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W), .WINDOW(WINDOW)) dut (
      .clk_i(clk), .arst_i(arst), .data_i(data), .data_val_i(data_val), .clear_i(clear),
      .thresh_i(thresh), .sum_o(sum), .sum_val_o(sum_val), .above_o(above),
`ifdef POPCOUNT_WIN_AVG_EN
      .avg_o(avg),
`endif
      .fill_o(fill));

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input vec_t v);
      check({tag, ".sum"}, int'(sum), v.sum);
      check({tag, ".sum_val"}, int'(sum_val), int'(v.sv));
      check({tag, ".above"}, int'(above), int'(v.above));
      check({tag, ".fill"}, int'(fill), int'(v.fill));
`ifdef POPCOUNT_WIN_AVG_EN
      if (v.sv) check({tag, ".avg"}, int'(avg), v.avg);
`endif
   endtask

   task automatic step(input vec_t v);
      data_val = v.val;
      clear    = v.clr;
      data     = CNT_W'(v.data);
      thresh   = SUM_W'(v.thr);
      @(posedge clk);
      #1;
      data_val = 1'b0;
      clear    = 1'b0;
   endtask

   function automatic vec_t mk(bit val, bit clr, int d, int thr, int s, bit sv, bit ab, bit fl, int av);
      vec_t v;
      v.val = val; v.clr = clr; v.data = d; v.thr = thr;
      v.sum = s; v.sv = sv; v.above = ab; v.fill = fl; v.avg = av;
      return v;
   endfunction

   initial begin
      vec_t z, r;
      //            val clr data thr  sum sv ab fl avg
      vecs.push_back(mk(1, 0,  1, 40,   0, 0, 0, 0,  0));
      vecs.push_back(mk(1, 0,  2, 40,   0, 0, 0, 0,  0));
      vecs.push_back(mk(1, 0,  3, 40,   0, 0, 0, 0,  0));
      vecs.push_back(mk(1, 0,  4, 40,  10, 1, 0, 1,  2));
      vecs.push_back(mk(1, 0,  5, 40,  14, 1, 0, 1,  3));
      vecs.push_back(mk(1, 0, 32, 40,  44, 1, 1, 1, 11));
      vecs.push_back(mk(1, 0,  0, 44,  41, 1, 0, 1, 10));
      vecs.push_back(mk(0, 0,  9,  0,  41, 0, 0, 1,  0));
      vecs.push_back(mk(0, 0,  9,  0,  41, 0, 0, 1,  0));
      vecs.push_back(mk(0, 0,  9,  0,  41, 0, 0, 1,  0));
      vecs.push_back(mk(1, 0,  8, 44,  45, 1, 1, 1, 11));
      vecs.push_back(mk(1, 1,  7, 44,   0, 0, 0, 0,  0));
      vecs.push_back(mk(1, 0, 32,100,   0, 0, 0, 0,  0));
      vecs.push_back(mk(1, 0, 32,100,   0, 0, 0, 0,  0));
      vecs.push_back(mk(1, 0, 32,100,   0, 0, 0, 0,  0));
      vecs.push_back(mk(1, 0, 32,100, 128, 1, 1, 1, 32));
      vecs.push_back(mk(0, 0,  0,200, 128, 0, 1, 1,  0));
      vecs.push_back(mk(1, 0,  3, 40,  99, 1, 1, 1, 24));
      vecs.push_back(mk(1, 0,  4, 40,  71, 1, 1, 1, 17));
      vecs.push_back(mk(1, 0,  5, 40,  44, 1, 1, 1, 11));
      vecs.push_back(mk(1, 0, 32, 44,  44, 1, 0, 1, 11));

      z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      check_all("reset_in", z);
      @(posedge clk);
      #1;
      arst = 1'b0;
      check_all("reset_out", z);

      foreach (vecs[i]) begin
         step(vecs[i]);
         check_all($sformatf("vec%0d", i), vecs[i]);
      end

      #3;
      arst = 1'b1;
      #1;
      check_all("async_rst", z);
      #1;
      arst = 1'b0;

      for (int i = 0; i < 3; i++) begin
         r = mk(1, 0, 1, 2, 0, 0, 0, 0, 0);
         step(r);
         check_all($sformatf("refill%0d", i), r);
      end
      r = mk(1, 0, 1, 2, 4, 1, 1, 1, 1);
      step(r);
      check_all("refill3", r);
      r = mk(0, 0, 0, 2, 4, 0, 1, 1, 0);
      step(r);
      check_all("refill_idle", r);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
